// File: rtl/gmii_tx_pkg.sv
// Shared definitions for the GMII transmit scheduler: FSM state encoding,
// the fixed framing bytes and the registered GMII output bundle.
package gmii_tx_pkg;

  // One-hot state encoding of the per-frame scheduler FSM.
  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_PREAMBLE = 5'b00010,
    ST_DATA     = 5'b00100,
    ST_PAD      = 5'b01000,
    ST_IPG      = 5'b10000
  } tx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] PAD_BYTE      = 8'h00;

  // Everything driven towards TRANSMIT in one cycle.
  typedef struct packed {
    logic       en;
    logic       er;
    logic [7:0] txd;
  } gmii_out_t;

  // Bus value while no frame is on the wire.
  localparam gmii_out_t GMII_IDLE = '{en: 1'b0, er: 1'b0, txd: 8'h00};

endpackage : gmii_tx_pkg

// File: rtl/gmii_rr_arbiter.sv
// Round-robin request picker: returns a one-hot grant for the first
// requester at or after ptr, wrapping around. Purely combinational; the
// pointer is owned and advanced by the parent.
module gmii_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [PTR_W-1:0] ptr,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant
);

  // Walk the requesters in pointer order and keep the first one found.
  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule : gmii_rr_arbiter

// File: rtl/gmii_tx_scheduler.sv
// Shares the GMII transmit input between N_REQ byte-stream sources.
// One frame at a time is granted round-robin; the scheduler prepends
// preamble+SFD, forwards the granted source's bytes, turns a dropped
// valid into an errored abort byte, and holds the inter-packet gap.
// Optional build macro: GMII_TX_PAD_EN zero-pads short frames up to
// MIN_FRAME_LEN data bytes; when undefined the PAD path is not built.
module gmii_tx_scheduler
  import gmii_tx_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int PREAMBLE_LEN  = 7,
  parameter int IPG_CYCLES    = 12,
  parameter int MIN_FRAME_LEN = 60,
  parameter int CNT_W         = 8
) (
  input  logic                 GTX_CLK,
  input  logic                 mr_main_reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  input  logic [N_REQ-1:0]     req_err,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     grant,
  output logic [7:0]           TXD,
  output logic                 TX_EN,
  output logic                 TX_ER,
  output logic                 busy,
  output logic                 underrun,
  output logic                 frame_done
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN);
  localparam logic [CNT_W-1:0] IPG_LAST = CNT_W'(IPG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Counters must be able to hold every configured length.
  if ((MIN_FRAME_LEN >= (1 << CNT_W)) || (PREAMBLE_LEN >= (1 << CNT_W)) ||
      (IPG_CYCLES < 1) || (IPG_CYCLES > (1 << CNT_W))) begin : g_param_check
    $error("gmii_tx_scheduler: a length parameter does not fit CNT_W");
  end

  // Reset: asserts asynchronously, releases on a clock edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  tx_state_e          state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  gmii_out_t          tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               underrun_q, underrun_d;
  logic               frame_done_q, frame_done_d;

  logic [N_REQ-1:0]   arb_grant;
  logic [PTR_W-1:0]   g_idx;
  logic               g_valid;
  logic               g_last;
  logic               g_err;
  logic [7:0]         g_data;
  logic [PTR_W-1:0]   ptr_next;
  logic [CNT_W-1:0]   byte_inc;

  // Two-stage release shift; cleared the moment mr_main_reset goes low.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset release synchroniser.
  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n = rst_sync_q[1];

  gmii_rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .ptr   (ptr_q),
    .req   (req_valid),
    .grant (arb_grant)
  );

  // Select the byte stream of the currently granted source.
  always_comb begin
    g_idx   = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_err   = 1'b0;
    g_data  = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        g_idx   = PTR_W'(i);
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_err   = req_err[i];
        g_data  = req_data[8*i +: 8];
      end
    end
  end

  assign ptr_next = (g_idx == PTR_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
  assign byte_inc = (byte_cnt_q == CNT_MAX) ? byte_cnt_q : byte_cnt_q + 1'b1;

`ifdef GMII_TX_PAD_EN
  // True while the frame, including the byte sent this cycle, is short.
  logic [CNT_W:0] byte_plus1;
  logic           short_frame;
  assign byte_plus1  = {1'b0, byte_cnt_q} + (CNT_W+1)'(1);
  assign short_frame = byte_plus1 < (CNT_W+1)'(MIN_FRAME_LEN);
`endif

  // Next-state and next-output logic of the frame scheduler.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    byte_cnt_d   = byte_cnt_q;
    tx_d         = GMII_IDLE;
    underrun_d   = 1'b0;
    frame_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d      = '0;
        byte_cnt_d = '0;
        if (|req_valid) begin
          grant_d = arb_grant;
          state_d = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        tx_d.en = 1'b1;
        if (cnt_q < PRE_LAST) begin
          tx_d.txd = PREAMBLE_BYTE;
          cnt_d    = cnt_q + 1'b1;
        end else begin
          tx_d.txd = SFD_BYTE;
          cnt_d    = '0;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_d.en = 1'b1;
        if (g_valid) begin
          tx_d.er    = g_err;
          tx_d.txd   = g_data;
          byte_cnt_d = byte_inc;
          if (g_last) begin
`ifdef GMII_TX_PAD_EN
            if (short_frame) begin
              state_d = ST_PAD;
            end else begin
              state_d      = ST_IPG;
              frame_done_d = 1'b1;
            end
`else
            state_d      = ST_IPG;
            frame_done_d = 1'b1;
`endif
          end
        end else begin
          // Source starved mid-frame: poison the frame and give up the bus.
          tx_d.er    = 1'b1;
          tx_d.txd   = 8'h00;
          underrun_d = 1'b1;
          state_d    = ST_IPG;
        end
      end
`ifdef GMII_TX_PAD_EN
      ST_PAD: begin
        tx_d.en    = 1'b1;
        tx_d.txd   = PAD_BYTE;
        byte_cnt_d = byte_inc;
        if (!short_frame) begin
          frame_done_d = 1'b1;
          state_d      = ST_IPG;
        end
      end
`endif
      ST_IPG: begin
        if (cnt_q == IPG_LAST) begin
          cnt_d   = '0;
          grant_d = '0;
          ptr_d   = ptr_next;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and all registered outputs.
  always_ff @(posedge GTX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      byte_cnt_q   <= '0;
      tx_q         <= GMII_IDLE;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      underrun_q   <= underrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign req_ready  = (state_q == ST_DATA) ? grant_q : '0;
  assign grant      = grant_q;
  assign TXD        = tx_q.txd;
  assign TX_EN      = tx_q.en;
  assign TX_ER      = tx_q.er;
  assign busy       = busy_q;
  assign underrun   = underrun_q;
  assign frame_done = frame_done_q;

endmodule : gmii_tx_scheduler
